// File: rtl/rv523_phase_gen.sv
// rtl/rv523_phase_gen.sv - two-phase non-overlapping clock generator with run/step control
// Optional single-step support is enabled by defining PHASE_STEP_EN.
module rv523_phase_gen #(
  parameter int unsigned P1_LEN  = 2,
  parameter int unsigned P2_LEN  = 2,
  parameter int unsigned GAP_LEN = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_run,
  input  logic             i_step,
  output logic             o_phi1,
  output logic             o_nphi1,
  output logic             o_phi2,
  output logic             o_nphi2,
  output logic             o_busy,
  output logic             o_cyc_done,
  output logic [CNT_W-1:0] o_cyc_cnt
);

  localparam int unsigned MAX_LEN = (P1_LEN > P2_LEN) ?
                                    ((P1_LEN > GAP_LEN) ? P1_LEN : GAP_LEN) :
                                    ((P2_LEN > GAP_LEN) ? P2_LEN : GAP_LEN);
  localparam int unsigned DW = $clog2(MAX_LEN) + 1;

  typedef enum logic [2:0] {
    S_HALT = 3'd0,
    S_PH1  = 3'd1,
    S_GAP1 = 3'd2,
    S_PH2  = 3'd3,
    S_GAP2 = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_nstate;
  logic [DW-1:0]    r_dur;
  logic [DW-1:0]    w_ndur;
  logic             w_last;
  logic             w_go;
  logic             w_ndone;
  logic             r_phi1;
  logic             r_nphi1;
  logic             r_phi2;
  logic             r_nphi2;
  logic             r_busy;
  logic             r_cyc_done;
  logic [CNT_W-1:0] r_cyc_cnt;

`ifdef PHASE_STEP_EN
  logic r_step_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_step_d <= 1'b0;
    else          r_step_d <= i_step;
  end

  // Edges seen outside HALT are simply dropped by the FSM, so no queuing.
  assign w_go = i_run | (i_step & ~r_step_d);
`else
  logic w_unused_step;
  assign w_unused_step = i_step;
  assign w_go          = i_run;
`endif

  // r_dur holds the cycles remaining in the current state after this one.
  always_comb begin
    w_nstate = r_state;
    w_ndur   = r_dur;
    w_last   = (r_dur == '0);
    if (r_state != S_HALT && !w_last) w_ndur = r_dur - 1'b1;
    case (r_state)
      S_HALT: if (w_go) begin
        w_nstate = S_PH1;
        w_ndur   = DW'(P1_LEN - 1);
      end
      S_PH1: if (w_last) begin
        w_nstate = S_GAP1;
        w_ndur   = DW'(GAP_LEN - 1);
      end
      S_GAP1: if (w_last) begin
        w_nstate = S_PH2;
        w_ndur   = DW'(P2_LEN - 1);
      end
      S_PH2: if (w_last) begin
        w_nstate = S_GAP2;
        w_ndur   = DW'(GAP_LEN - 1);
      end
      S_GAP2: if (w_last) begin
        if (i_run) begin
          w_nstate = S_PH1;
          w_ndur   = DW'(P1_LEN - 1);
        end else begin
          w_nstate = S_HALT;
          w_ndur   = '0;
        end
      end
      default: begin
        w_nstate = S_HALT;
        w_ndur   = '0;
      end
    endcase
    w_ndone = (w_nstate == S_GAP2) && (w_ndur == '0);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_HALT;
      r_dur      <= '0;
      r_phi1     <= 1'b0;
      r_nphi1    <= 1'b1;
      r_phi2     <= 1'b0;
      r_nphi2    <= 1'b1;
      r_busy     <= 1'b0;
      r_cyc_done <= 1'b0;
      r_cyc_cnt  <= '0;
    end else begin
      r_state    <= w_nstate;
      r_dur      <= w_ndur;
      r_phi1     <= (w_nstate == S_PH1);
      r_nphi1    <= (w_nstate != S_PH1);
      r_phi2     <= (w_nstate == S_PH2);
      r_nphi2    <= (w_nstate != S_PH2);
      r_busy     <= (w_nstate != S_HALT);
      r_cyc_done <= w_ndone;
      if (w_ndone) r_cyc_cnt <= r_cyc_cnt + CNT_W'(1);
    end
  end

  assign o_phi1     = r_phi1;
  assign o_nphi1    = r_nphi1;
  assign o_phi2     = r_phi2;
  assign o_nphi2    = r_nphi2;
  assign o_busy     = r_busy;
  assign o_cyc_done = r_cyc_done;
  assign o_cyc_cnt  = r_cyc_cnt;

endmodule
